// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the serial line, the divisor register port, the receive-data
// register port and the status outputs of uart_rx_fifo.
//   slave  modport : the receiver block (drives status and read data)
//   master modport : the surrounding CPU / console side
// Signals:
//   ser_rx         serial input, idle high
//   reg_div_we/di  byte-lane divisor write; reg_div_do current divisor
//   reg_dat_re     pop strobe; reg_dat_do FIFO head byte, zero-extended
//   rx_valid       FIFO not empty; rx_count FIFO occupancy
//   rx_overrun, rx_frame_err, rx_parity_err  sticky error flags
//   clr_err        clears all sticky flags
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 3
) ();
  logic               ser_rx;
  logic [3:0]         reg_div_we;
  logic [31:0]        reg_div_di;
  logic [31:0]        reg_div_do;
  logic               reg_dat_re;
  logic [31:0]        reg_dat_do;
  logic               rx_valid;
  logic [FIFO_AW:0]   rx_count;
  logic               rx_overrun;
  logic               rx_frame_err;
  logic               rx_parity_err;
  logic               clr_err;

  modport slave (
    input  ser_rx, reg_div_we, reg_div_di, reg_dat_re, clr_err,
    output reg_div_do, reg_dat_do, rx_valid, rx_count,
           rx_overrun, rx_frame_err, rx_parity_err
  );

  modport master (
    output ser_rx, reg_div_we, reg_div_di, reg_dat_re, clr_err,
    input  reg_div_do, reg_dat_do, rx_valid, rx_count,
           rx_overrun, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Console serial receiver: 2-flop synchroniser, 8N1 deserialiser FSM and a
// 2**FIFO_AW byte receive FIFO with sticky overrun / framing error flags.
// Ports:
//   clk    system clock (16 MHz on the board)
//   reset  asynchronous, active-high reset
//   bus    uart_rx_fifo_if.slave (serial line, divisor and data registers,
//          status flags)
// Build option:
//   UART_RX_PARITY_EN  when defined, frames carry an even-parity bit between
//                      bit 7 and the stop bit; a mismatch discards the byte
//                      and sets sticky rx_parity_err. When undefined the
//                      frames are 8N1 and rx_parity_err is tied to 0.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] DIV_RESET = 32'd53333
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: data ones plus the parity bit must be an even count.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction
`endif

  // ---------------- state ----------------
  logic [1:0]          sync_q;
  logic                prev_q;
  logic [31:0]         div_q, div_d;
  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [NB-1:0]       shift_q, shift_d;
  logic [31:0]         div_lat_q, div_lat_d;
  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_AW:0]    wr_ptr_q, rd_ptr_q;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;

  // ---------------- combinational helpers ----------------
  logic                rx_s;
  logic                fall_s;
  logic                expire_s;
  logic [31:0]         eff_div_s;
  logic                push_req_s;
  logic                frame_set_s;
  logic [FIFO_AW:0]    count_s;
  logic                empty_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                ovr_set_s;

  assign rx_s      = sync_q[1];
  assign fall_s    = prev_q & ~sync_q[1];
  assign expire_s  = (cnt_q == 32'd1);
  assign eff_div_s = (div_q < 32'd4) ? 32'd4 : div_q;

  // Pointers are one bit wider than the address so full and empty differ.
  assign count_s   = wr_ptr_q - rd_ptr_q;
  assign empty_s   = (count_s == '0);
  assign full_s    = (count_s == FULL_CNT);
  assign pop_s     = bus.reg_dat_re & ~empty_s;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_s    = push_req_s & (~full_s | pop_s);
  assign ovr_set_s = push_req_s & full_s & ~pop_s;

  // Input synchroniser plus previous-sample flop for start-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], bus.ser_rx};
      prev_q <= sync_q[1];
    end
  end

  // Divisor register next state: per-byte-lane writes.
  always_comb begin
    div_d = div_q;
    for (int i = 0; i < 4; i++) begin
      if (bus.reg_div_we[i]) begin
        div_d[8*i +: 8] = bus.reg_div_di[8*i +: 8];
      end else begin
        div_d[8*i +: 8] = div_q[8*i +: 8];
      end
    end
  end

  // Divisor register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= DIV_RESET;
    end else begin
      div_q <= div_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set_s;
`endif

  // Receiver FSM next-state and strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    div_lat_d   = div_lat_q;
    push_req_s  = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set_s   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Divisor is latched here so mid-frame writes only affect later frames.
        if (fall_s) begin
          div_lat_d = eff_div_s;
          cnt_d     = eff_div_s >> 1;
          state_d   = ST_START;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_START: begin
        if (expire_s) begin
          if (!rx_s) begin
            cnt_d   = div_lat_q;
            bit_d   = 4'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_DATA: begin
        if (expire_s) begin
          // LSB first: each new bit enters at the top and shifts down.
          shift_d = {rx_s, shift_q[NB-1:1]};
          cnt_d   = div_lat_q;
          if (bit_q == 4'(NB - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_STOP: begin
        if (expire_s) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (parity_ok(shift_q[7:0], shift_q[8])) begin
              push_req_s = 1'b1;
            end else begin
              par_set_s  = 1'b1;
            end
`else
            push_req_s = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_set_s = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Receiver FSM state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      bit_q     <= 4'd0;
      shift_q   <= '0;
      div_lat_q <= 32'd4;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q[7:0];
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Sticky error flags next state; clearing wins over a same-cycle set.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (bus.clr_err) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      overrun_d   = overrun_q | ovr_set_s;
      frame_err_d = frame_err_q | frame_set_s;
    end
  end

  // Sticky error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // Sticky parity error flag; clearing wins over a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else if (bus.clr_err) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_q | par_set_s;
    end
  end

  assign bus.rx_parity_err = parity_err_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  // Outputs decode directly from registered state.
  assign bus.reg_div_do   = div_q;
  assign bus.reg_dat_do   = empty_s ? 32'd0 : {24'd0, mem_q[rd_ptr_q[FIFO_AW-1:0]]};
  assign bus.rx_valid     = ~empty_s;
  assign bus.rx_count     = count_s;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Scenario bench for uart_rx_fifo. Bytes expected to land in the FIFO are
// queued when their frame is sent and popped when the DUT presents them.
// Define UART_RX_PARITY_EN for both DUT and bench to exercise parity frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
  localparam int AW  = 3;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset;

  uart_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  uart_rx_fifo #(.FIFO_AW(AW), .DIV_RESET(32'd53333)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ser_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  task automatic pulse_pop();
    tick();
    bus.reg_dat_re = 1'b1;
    tick();
    bus.reg_dat_re = 1'b0;
  endtask

  task automatic pulse_clr();
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.reg_div_do !== 32'd53333) begin n_fail++; $display("FAIL reset_div: got %0d expected 53333", bus.reg_div_do); end
    n_tests++;
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
    n_tests++;
    if (bus.reg_dat_do !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", bus.reg_dat_do); end
    n_tests++;
    if (bus.rx_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.rx_count); end
    n_tests++;
    if ({bus.rx_overrun, bus.rx_frame_err, bus.rx_parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.rx_overrun, bus.rx_frame_err, bus.rx_parity_err});
    end
  endtask

  task automatic test_div_write();
    tick();
    bus.reg_div_we = 4'hF;
    bus.reg_div_di = 32'd16;
    tick();
    bus.reg_div_we = 4'h0;
    @(negedge clk);
    n_tests++;
    if (bus.reg_div_do !== 32'd16) begin n_fail++; $display("FAIL div_all_lanes: got %h expected 00000010", bus.reg_div_do); end
    tick();
    bus.reg_div_we = 4'b0010;
    bus.reg_div_di = 32'hDEAD_AB77;
    tick();
    bus.reg_div_we = 4'h0;
    @(negedge clk);
    n_tests++;
    if (bus.reg_div_do !== 32'h0000_AB10) begin n_fail++; $display("FAIL div_one_lane: got %h expected 0000ab10", bus.reg_div_do); end
    tick();
    bus.reg_div_we = 4'hF;
    bus.reg_div_di = 32'd16;
    tick();
    bus.reg_div_we = 4'h0;
  endtask

  task automatic test_single();
    logic ok;
    logic [7:0] exp;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_valid: got rx_valid=%b expected 1 within budget", bus.rx_valid); end
    exp = exp_q.pop_front();
    n_tests++;
    if (bus.reg_dat_do !== {24'd0, exp}) begin n_fail++; $display("FAIL single_data: got %h expected %h", bus.reg_dat_do, {24'd0, exp}); end
    pulse_pop();
    @(negedge clk);
    n_tests++;
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", bus.rx_valid); end
    n_tests++;
    if (bus.reg_dat_do !== 32'd0) begin n_fail++; $display("FAIL single_pop_dat: got %h expected 0", bus.reg_dat_do); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1, 1'b0);
    end
    repeat (4) tick();
    @(negedge clk);
    n_tests++;
    if (bus.rx_count !== 4'd8) begin n_fail++; $display("FAIL ovr_count: got %0d expected 8", bus.rx_count); end
    n_tests++;
    if (bus.rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", bus.rx_overrun); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_tests++;
      if (bus.reg_dat_do !== {24'd0, exp}) begin n_fail++; $display("FAIL ovr_data[%0d]: got %h expected %h", i, bus.reg_dat_do, {24'd0, exp}); end
      pulse_pop();
    end
    @(negedge clk);
    n_tests++;
    if (bus.rx_valid !== 1'b0 || bus.rx_count !== 4'd0) begin
      n_fail++; $display("FAIL ovr_drained: got valid=%b count=%0d expected valid=0 count=0", bus.rx_valid, bus.rx_count);
    end
    pulse_clr();
    @(negedge clk);
    n_tests++;
    if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", bus.rx_overrun); end
  endtask

  task automatic test_glitch();
    bus.ser_rx = 1'b0;
    repeat (5) tick();
    bus.ser_rx = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    n_tests++;
    if (bus.rx_count !== 4'd0 || bus.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_push: got count=%0d valid=%b expected 0/0", bus.rx_count, bus.rx_valid);
    end
    n_tests++;
    if (bus.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b expected 0", bus.rx_frame_err); end
  endtask

  task automatic test_frame_err();
    logic ok;
    logic [7:0] exp;
    send_frame(8'h55, 1'b0, 1'b0);
    bus.ser_rx = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    n_tests++;
    if (bus.rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", bus.rx_frame_err); end
    n_tests++;
    if (bus.rx_count !== 4'd0) begin n_fail++; $display("FAIL ferr_nopush: got %0d expected 0", bus.rx_count); end
    pulse_clr();
    @(negedge clk);
    n_tests++;
    if (bus.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", bus.rx_frame_err); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) ok = 1'b1;
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || bus.reg_dat_do !== {24'd0, exp}) begin
      n_fail++; $display("FAIL ferr_recover: got valid=%b dat=%h expected 1/%h", bus.rx_valid, bus.reg_dat_do, {24'd0, exp});
    end
    pulse_pop();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] exp;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.reg_dat_do !== {24'd0, exp}) begin
      n_fail++; $display("FAIL par_good: got valid=%b dat=%h expected 1/%h", bus.rx_valid, bus.reg_dat_do, {24'd0, exp});
    end
    pulse_pop();
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (bus.rx_parity_err !== 1'b1 || bus.rx_count !== 4'd0) begin
      n_fail++; $display("FAIL par_bad: got perr=%b count=%0d expected 1/0", bus.rx_parity_err, bus.rx_count);
    end
    pulse_clr();
    @(negedge clk);
    n_tests++;
    if (bus.rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL par_clear: got %b expected 0", bus.rx_parity_err); end
  endtask
`endif

  task automatic test_reset_midframe();
    bus.ser_rx = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    #2;
    n_tests++;
    if (bus.reg_div_do !== 32'd53333 || bus.rx_count !== 4'd0) begin
      n_fail++; $display("FAIL midframe_reset: got div=%0d count=%0d expected 53333/0", bus.reg_div_do, bus.rx_count);
    end
    bus.ser_rx = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // Hard stop if anything stalls far beyond the expected run length.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ser_rx     = 1'b1;
    bus.reg_div_we = 4'h0;
    bus.reg_div_di = 32'd0;
    bus.reg_dat_re = 1'b0;
    bus.clr_err    = 1'b0;
    reset          = 1'b1;
    test_reset();
    test_div_write();
    test_single();
    test_overrun();
    test_glitch();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
